// File: rtl/crc32_pkg.sv
// Shared constants and state type for the streaming CRC-32 engine.
// Reflected PNG/zlib CRC-32: poly 0xEDB88320, init and final XOR all ones.
package crc32_pkg;

    localparam logic [31:0] CRC32_POLY_REF = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT     = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_XOROUT   = 32'hFFFFFFFF;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/crc32_stream_if.sv
// Beat and result signals of the CRC-32 engine; master drives beats, slave is the engine.
interface crc32_stream_if #(
    parameter int DATA_WD = 32,
    parameter int CNT_WD  = 32
);
    logic                   start_i;
    logic                   val_i;
    logic [DATA_WD-1:0]     dat_i;
    logic [DATA_WD/8-1:0]   keep_i;
    logic                   lst_i;
    logic                   busy_o;
    logic                   done_o;
    logic                   val_o;
    logic [31:0]            dat_o;
    logic [CNT_WD-1:0]      cnt_o;

    modport master (
        output start_i, val_i, dat_i, keep_i, lst_i,
        input  busy_o, done_o, val_o, dat_o, cnt_o
    );

    modport slave (
        input  start_i, val_i, dat_i, keep_i, lst_i,
        output busy_o, done_o, val_o, dat_o, cnt_o
    );
endinterface

// File: rtl/crc32_byte_step.sv
// Combinational reflected CRC-32 update for one byte, LSB first.
module crc32_byte_step
    import crc32_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  byte_in,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in ^ {24'h000000, byte_in};
        for (int b = 0; b < 8; b++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REF) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/crc32_stream.sv
// Streaming CRC-32 engine: 1..8 bytes per beat, byte mask on the last beat,
// returns the post-XORed CRC and byte count one cycle after the last beat.
//
//   state | meaning
//   IDLE  | no message open; beats ignored unless start_i
//   RUN   | message open; every valid beat is folded in
module crc32_stream
    import crc32_pkg::*;
#(
    parameter int DATA_WD = 32,
    parameter int CNT_WD  = 32
) (
    input  logic           clk,
    input  logic           rstn,
    crc32_stream_if.slave  bus
);

    localparam int LANES = DATA_WD / 8;

    state_t             state_q, state_d;
    logic [31:0]        crc_q, crc_d;
    logic [CNT_WD-1:0]  cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [31:0]        res_crc_q, res_crc_d;
    logic [CNT_WD-1:0]  res_cnt_q, res_cnt_d;

    logic               proc;
    logic [LANES-1:0]   lane_use;
    logic [31:0]        crc_base;
    logic [31:0]        crc_chain;
    logic [CNT_WD-1:0]  cnt_base;
    logic [CNT_WD-1:0]  nbytes;

    // start_i restarts the message, so a same-cycle beat folds into the init value
    assign proc     = bus.val_i && ((state_q == RUN) || bus.start_i);
    assign lane_use = bus.lst_i ? bus.keep_i : '1;
    assign crc_base = bus.start_i ? CRC32_INIT : crc_q;
    assign cnt_base = bus.start_i ? '0 : cnt_q;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [31:0] c_in;
        logic [31:0] c_step;
        logic [31:0] c_out;

        if (g == 0) begin : g_first
            assign c_in = crc_base;
        end else begin : g_next
            assign c_in = g_lane[g-1].c_out;
        end

        crc32_byte_step u_step (
            .crc_in  (c_in),
            .byte_in (bus.dat_i[8*g +: 8]),
            .crc_out (c_step)
        );

        assign c_out = lane_use[g] ? c_step : c_in;
    end

    assign crc_chain = g_lane[LANES-1].c_out;

    always_comb begin
        nbytes = '0;
        for (int i = 0; i < LANES; i++) begin
            nbytes = nbytes + CNT_WD'(lane_use[i]);
        end
    end

    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        res_crc_d = res_crc_q;
        res_cnt_d = res_cnt_q;

        case (state_q)
            IDLE:    if (bus.start_i) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = IDLE;
        endcase

        if (bus.start_i) begin
            crc_d = CRC32_INIT;
            cnt_d = '0;
        end

        if (proc) begin
            crc_d = crc_chain;
            cnt_d = cnt_base + nbytes;
            if (bus.lst_i) begin
                state_d   = IDLE;
                done_d    = 1'b1;
                res_crc_d = crc_chain ^ CRC32_XOROUT;
                res_cnt_d = cnt_base + nbytes;
                crc_d     = CRC32_INIT;
                cnt_d     = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            crc_q     <= CRC32_INIT;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            res_crc_q <= '0;
            res_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            res_crc_q <= res_crc_d;
            res_cnt_q <= res_cnt_d;
        end
    end

    assign bus.busy_o = (state_q == RUN);
    assign bus.done_o = done_q;
    assign bus.val_o  = done_q;
    assign bus.dat_o  = res_crc_q;
    assign bus.cnt_o  = res_cnt_q;

endmodule

// File: tb/tb_crc32_stream.sv
// Self-checking bench: known-answer table, random messages against a table-driven
// CRC model, and hand-written restart / reset / back-to-back / wrap sequences.
module tb_crc32_stream;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    crc32_stream_if #(.DATA_WD(32), .CNT_WD(32)) bus32 ();
    crc32_stream_if #(.DATA_WD(8),  .CNT_WD(4))  bus8 ();

    crc32_stream #(.DATA_WD(32), .CNT_WD(32)) u_dut32 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus32)
    );

    crc32_stream #(.DATA_WD(8), .CNT_WD(4)) u_dut8 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus8)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] crc_tab [256];

    typedef struct {
        logic [95:0] msg;
        int          len;
        logic [31:0] crc;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_crc(input logic [7:0] q[$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (q[i]) c = crc_tab[c[7:0] ^ q[i]] ^ (c >> 8);
        return ~c;
    endfunction

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle32();
        bus32.start_i = 1'b0;
        bus32.val_i   = 1'b0;
        bus32.lst_i   = 1'b0;
        bus32.keep_i  = '0;
        bus32.dat_i   = '0;
    endtask

    task automatic send32(input logic [7:0] m[$], input logic [31:0] exp_crc,
                          input bit junk, input bit gaps);
        int n;
        int nb;
        int idx;
        logic [31:0] d;
        logic [3:0]  k;
        n   = m.size();
        nb  = (n == 0) ? 1 : (n + 3) / 4;
        idx = 0;
        for (int b = 0; b < nb; b++) begin
            if (gaps && b > 0 && $urandom_range(0, 2) == 0) begin
                bus32.start_i = 1'b0;
                bus32.val_i   = 1'b0;
                bus32.lst_i   = 1'($urandom);
                bus32.dat_i   = $urandom;
                cycle();
                check("gap_busy", bus32.busy_o, 1);
                check("gap_done", bus32.done_o, 0);
            end
            d = junk ? $urandom : 32'h0;
            k = 4'h0;
            for (int l = 0; l < 4; l++) begin
                if (idx < n) begin
                    d[8*l +: 8] = m[idx];
                    k[l] = 1'b1;
                    idx++;
                end
            end
            bus32.start_i = (b == 0);
            bus32.val_i   = 1'b1;
            bus32.lst_i   = (b == nb - 1);
            bus32.keep_i  = (b == nb - 1) ? k : (junk ? 4'($urandom) : 4'h0);
            bus32.dat_i   = d;
            cycle();
            if (b != nb - 1) begin
                check("beat_busy", bus32.busy_o, 1);
                check("beat_done", bus32.done_o, 0);
            end
        end
        idle32();
        check("msg_done", bus32.done_o, 1);
        check("msg_val", bus32.val_o, 1);
        check("msg_crc", bus32.dat_o, exp_crc);
        check("msg_cnt", bus32.cnt_o, n);
        check("msg_busy", bus32.busy_o, 0);
        cycle();
        check("pulse_end", bus32.done_o, 0);
        check("hold_crc", bus32.dat_o, exp_crc);
    endtask

    task automatic send8(input logic [7:0] m[$], input logic [31:0] exp_crc, input logic [3:0] exp_cnt);
        for (int b = 0; b < m.size(); b++) begin
            bus8.start_i = (b == 0);
            bus8.val_i   = 1'b1;
            bus8.lst_i   = (b == m.size() - 1);
            bus8.keep_i  = 1'b1;
            bus8.dat_i   = m[b];
            cycle();
            if (b != m.size() - 1) check("b8_done_early", bus8.done_o, 0);
        end
        bus8.start_i = 1'b0;
        bus8.val_i   = 1'b0;
        bus8.lst_i   = 1'b0;
        check("b8_done", bus8.done_o, 1);
        check("b8_crc", bus8.dat_o, exp_crc);
        check("b8_cnt", bus8.cnt_o, exp_cnt);
        cycle();
        check("b8_pulse_end", bus8.done_o, 0);
    endtask

    initial begin
        logic [7:0]  q[$];
        logic [31:0] c;
        int          len;

        for (int i = 0; i < 256; i++) begin
            c = 32'(i);
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tab[i] = c;
        end

        vecs[0] = '{msg: 96'(""),          len: 0, crc: 32'h00000000};
        vecs[1] = '{msg: 96'("a"),         len: 1, crc: 32'hE8B7BE43};
        vecs[2] = '{msg: 96'("abc"),       len: 3, crc: 32'h352441C2};
        vecs[3] = '{msg: 96'("IEND"),      len: 4, crc: 32'hAE426082};
        vecs[4] = '{msg: 96'("123456789"), len: 9, crc: 32'hCBF43926};

        idle32();
        bus8.start_i = 1'b0;
        bus8.val_i   = 1'b0;
        bus8.lst_i   = 1'b0;
        bus8.keep_i  = '0;
        bus8.dat_i   = '0;

        rstn = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", bus32.busy_o, 0);
        check("rst_done", bus32.done_o, 0);
        check("rst_val", bus32.val_o, 0);
        check("rst_crc", bus32.dat_o, 0);
        check("rst_cnt", bus32.cnt_o, 0);
        rstn = 1'b1;
        cycle();

        // known-answer table
        for (int v = 0; v < 5; v++) begin
            q.delete();
            for (int k = 0; k < vecs[v].len; k++) q.push_back(vecs[v].msg[8*(vecs[v].len-1-k) +: 8]);
            send32(q, vecs[v].crc, 1'b0, 1'b0);
        end

        // junk in masked lanes must not matter
        q.delete();
        for (int k = 0; k < 9; k++) q.push_back(vecs[4].msg[8*(8-k) +: 8]);
        send32(q, 32'hCBF43926, 1'b1, 1'b0);

        // byte-wide engine, then count wrap at 4 bits
        send8(q, 32'hCBF43926, 4'd9);
        q.delete();
        for (int k = 0; k < 20; k++) q.push_back(8'($urandom));
        send8(q, model_crc(q), 4'(20 % 16));

        // random messages vs model
        for (int r = 0; r < 40; r++) begin
            q.delete();
            len = $urandom_range(0, 21);
            for (int k = 0; k < len; k++) q.push_back(8'($urandom));
            send32(q, model_crc(q), 1'($urandom), 1'($urandom));
        end

        // restart mid-message then IEND
        bus32.start_i = 1'b1; bus32.val_i = 1'b1; bus32.lst_i = 1'b0; bus32.dat_i = $urandom;
        cycle();
        bus32.start_i = 1'b0; bus32.dat_i = $urandom;
        cycle();
        check("rs_busy", bus32.busy_o, 1);
        check("rs_done0", bus32.done_o, 0);
        bus32.start_i = 1'b1; bus32.lst_i = 1'b1; bus32.keep_i = 4'hF; bus32.dat_i = 32'h444E4549;
        cycle();
        idle32();
        check("rs_done", bus32.done_o, 1);
        check("rs_crc", bus32.dat_o, 32'hAE426082);
        check("rs_cnt", bus32.cnt_o, 4);
        cycle();
        check("rs_single", bus32.done_o, 0);

        // val_i in IDLE without start_i is ignored
        bus32.val_i = 1'b1; bus32.lst_i = 1'b1; bus32.keep_i = 4'hF;
        for (int i = 0; i < 3; i++) begin
            bus32.dat_i = $urandom;
            cycle();
            check("idle_busy", bus32.busy_o, 0);
            check("idle_done", bus32.done_o, 0);
            check("idle_hold", bus32.dat_o, 32'hAE426082);
        end
        idle32();

        // asynchronous reset mid-message
        bus32.start_i = 1'b1; bus32.val_i = 1'b1; bus32.dat_i = $urandom;
        cycle();
        bus32.start_i = 1'b0; bus32.dat_i = $urandom;
        cycle();
        idle32();
        #2 rstn = 1'b0;
        #1;
        check("arst_busy", bus32.busy_o, 0);
        check("arst_done", bus32.done_o, 0);
        check("arst_val", bus32.val_o, 0);
        check("arst_crc", bus32.dat_o, 0);
        check("arst_cnt", bus32.cnt_o, 0);
        @(negedge clk);
        rstn = 1'b1;
        cycle();
        q = '{8'h49, 8'h45, 8'h4E, 8'h44};
        send32(q, 32'hAE426082, 1'b0, 1'b0);

        // back-to-back: start in the done cycle
        bus32.start_i = 1'b1; bus32.val_i = 1'b1; bus32.lst_i = 1'b1;
        bus32.keep_i = 4'h7; bus32.dat_i = 32'hFF636261;
        cycle();
        check("b2b_done1", bus32.done_o, 1);
        check("b2b_crc1", bus32.dat_o, 32'h352441C2);
        check("b2b_cnt1", bus32.cnt_o, 3);
        bus32.keep_i = 4'hF; bus32.dat_i = 32'h444E4549;
        cycle();
        idle32();
        check("b2b_done2", bus32.done_o, 1);
        check("b2b_crc2", bus32.dat_o, 32'hAE426082);
        check("b2b_cnt2", bus32.cnt_o, 4);
        cycle();
        check("b2b_end", bus32.done_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
